// File: rtl/mem_seq_pkg.sv
// Shared encodings and helpers for the sub-word memory sequencer.
package mem_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_LW = 3'b000;
    localparam logic [OP_W-1:0] OP_LH = 3'b001;
    localparam logic [OP_W-1:0] OP_LB = 3'b010;
    localparam logic [OP_W-1:0] OP_SW = 3'b100;
    localparam logic [OP_W-1:0] OP_SH = 3'b101;
    localparam logic [OP_W-1:0] OP_SB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // True for the six defined opcodes.
    function automatic logic op_legal(input logic [OP_W-1:0] o);
        return (o == OP_LW) || (o == OP_LH) || (o == OP_LB) ||
               (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    // True for the three load opcodes.
    function automatic logic op_is_load(input logic [OP_W-1:0] o);
        return (o == OP_LW) || (o == OP_LH) || (o == OP_LB);
    endfunction

endpackage

// File: rtl/mem_subword_seq_if.sv
// Word-wide synchronous memory bus between the sequencer and the memory.
interface mem_subword_seq_if;
    import mem_seq_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_wr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_subword_merge.sv
// Low-lane sub-word merge for stores and zero-extension for loads.
module mem_subword_merge
    import mem_seq_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] wr_word_c,
    output logic [DATA_W-1:0] ld_word_c
);

    // Byte/half always sits in the low lane; addr[1:0] plays no part.
    always_comb begin
        wr_word_c = store_data;
        ld_word_c = word;
        case (op)
            OP_SH:   wr_word_c = {word[31:16], store_data[15:0]};
            OP_SB:   wr_word_c = {word[31:8], store_data[7:0]};
            OP_LH:   ld_word_c = {16'b0, word[15:0]};
            OP_LB:   ld_word_c = {24'b0, word[7:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_subword_seq.sv
// Multicycle LW/LH/LB/SW/SH/SB sequencer; sub-word stores are read-modify-write.
module mem_subword_seq
    import mem_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   store_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   load_data,
    mem_subword_seq_if.master   mem
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              rd_last_c;
    logic [OP_W-1:0]   merge_op_c;
    logic [DATA_W-1:0] merge_data_c;
    logic [DATA_W-1:0] wr_word_c;
    logic [DATA_W-1:0] ld_word_c;

    // Word register captures read data on the last RD cycle.
    always_comb begin
        rd_last_c = (state_q == S_RD) && (cnt_q == CNT_W'(MEM_LAT));
        word_d    = rd_last_c ? mem.mem_rdata : word_q;
    end

    // In IDLE the merge must see the live request (SW goes straight to WR).
    always_comb begin
        merge_op_c   = (state_q == S_IDLE) ? op : op_q;
        merge_data_c = (state_q == S_IDLE) ? store_data : data_q;
    end

    mem_subword_merge u_merge (
        .op         (merge_op_c),
        .word       (word_d),
        .store_data (merge_data_c),
        .wr_word_c  (wr_word_c),
        .ld_word_c  (ld_word_c)
    );

    // Next state, latched request and registered outputs decoded from next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        load_d      = load_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    addr_d = addr;
                    data_d = store_data;
                    if (!op_legal(op)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (op == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_RD: begin
                if (rd_last_c) begin
                    if (op_is_load(op_q)) begin
                        state_d = S_DONE;
                        load_d  = ld_word_c;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        mem_wr_d    = (state_d == S_WR);
        mem_wdata_d = (state_d == S_WR) ? wr_word_c : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_q      <= load_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign load_data     = load_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_subword_seq.sv
// Directed bench: two sequencers (MEM_LAT=1 and MEM_LAT=3) driven in lockstep.
module tb_mem_subword_seq;
    import mem_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;

    logic        busy1, done1, err1, busy3, done3, err3;
    logic [31:0] ld1, ld3;

    mem_subword_seq_if bus1();
    mem_subword_seq_if bus3();

    mem_subword_seq #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .store_data(sdata), .busy(busy1), .done(done1), .err(err1),
        .load_data(ld1), .mem(bus1)
    );

    mem_subword_seq #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .store_data(sdata), .busy(busy3), .done(done3), .err(err3),
        .load_data(ld3), .mem(bus3)
    );

    always #5 clk = ~clk;

    // Memory models with preload port, write counters and done counters.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    int          wr_cnt1 = 0, wr_cnt3 = 0, dn_cnt1 = 0, dn_cnt3 = 0;
    logic [31:0] last_wa1 = '0, last_wd1 = '0, last_wd3 = '0;
    logic [31:0] h3 [0:1];

    always @(posedge clk) begin
        if (pl_en) begin
            mem1[pl_a] <= pl_d;
            mem3[pl_a] <= pl_d;
        end else begin
            if (bus1.mem_wr) begin
                mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
                wr_cnt1  <= wr_cnt1 + 1;
                last_wa1 <= bus1.mem_addr;
                last_wd1 <= bus1.mem_wdata;
            end
            if (bus3.mem_wr) begin
                mem3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
                wr_cnt3  <= wr_cnt3 + 1;
                last_wd3 <= bus3.mem_wdata;
            end
        end
        if (done1) dn_cnt1 <= dn_cnt1 + 1;
        if (done3) dn_cnt3 <= dn_cnt3 + 1;
        h3[0] <= bus3.mem_addr;
        h3[1] <= h3[0];
    end

    // Latency-1 memory returns data in the address cycle; latency-3 only once
    // the address has been stable for three cycles.
    assign bus1.mem_rdata = mem1[bus1.mem_addr[7:0]];
    assign bus3.mem_rdata = (bus3.mem_addr == h3[0] && h3[0] == h3[1]) ?
                            mem3[bus3.mem_addr[7:0]] : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One transaction; cycle 0 is the start cycle. Returns done cycle, err at
    // done and first write cycle for each instance (-1 if never seen).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          input bit intrude,
                          output int lat1, output int lat3, output logic e1, output logic e3,
                          output int wc1, output int wc3);
        lat1 = -1; lat3 = -1; e1 = 1'b0; e3 = 1'b0; wc1 = -1; wc3 = -1;
        @(negedge clk);
        start = 1'b1; op = o; addr = a; sdata = d;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (intrude && c == 1) begin
                start = 1'b1; op = OP_SW; addr = 32'h80; sdata = 32'h0;
            end
            if (bus1.mem_wr && wc1 < 0) wc1 = c;
            if (bus3.mem_wr && wc3 < 0) wc3 = c;
            if (done1 && lat1 < 0) begin lat1 = c; e1 = err1; end
            if (done3 && lat3 < 0) begin lat3 = c; e3 = err3; end
            if (lat1 >= 0 && lat3 >= 0) break;
        end
        start = 1'b0;
    endtask

    int   l1, l3, w1, w3, wb1, wb3, db1, db3;
    logic e1, e3;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_err1", 32'(err1), 32'd0);
        check("rst_ld1", ld1, 32'h0);
        check("rst_wr1", 32'(bus1.mem_wr), 32'd0);
        check("rst_wdata1", bus1.mem_wdata, 32'h0);
        check("rst_addr1", bus1.mem_addr, 32'h0);

        preload(8'h40, 32'hAABBCCDD);
        preload(8'h44, 32'hAABBCCDD);
        preload(8'h80, 32'h0);

        // SB: read, merge low byte, write back
        wb1 = wr_cnt1;
        run_op(OP_SB, 32'h40, 32'h11223344, 1'b0, l1, l3, e1, e3, w1, w3);
        check("sb_lat1", 32'(l1), 32'd3);
        check("sb_lat3", 32'(l3), 32'd5);
        check("sb_wcyc1", 32'(w1), 32'd2);
        check("sb_wcyc3", 32'(w3), 32'd4);
        check("sb_err1", 32'(e1), 32'd0);
        check("sb_wdata1", last_wd1, 32'hAABBCC44);
        check("sb_wdata3", last_wd3, 32'hAABBCC44);
        check("sb_waddr1", last_wa1, 32'h40);
        check("sb_nwr1", 32'(wr_cnt1 - wb1), 32'd1);
        check("sb_mem1", mem1[8'h40], 32'hAABBCC44);
        check("sb_mem3", mem3[8'h40], 32'hAABBCC44);

        // SH then sub-word and word loads of the same word
        run_op(OP_SH, 32'h44, 32'h11223344, 1'b0, l1, l3, e1, e3, w1, w3);
        check("sh_lat1", 32'(l1), 32'd3);
        check("sh_lat3", 32'(l3), 32'd5);
        check("sh_mem1", mem1[8'h44], 32'hAABB3344);
        check("sh_mem3", mem3[8'h44], 32'hAABB3344);

        wb1 = wr_cnt1; wb3 = wr_cnt3;
        run_op(OP_LH, 32'h44, 32'h0, 1'b0, l1, l3, e1, e3, w1, w3);
        check("lh_lat1", 32'(l1), 32'd2);
        check("lh_lat3", 32'(l3), 32'd4);
        check("lh_ld1", ld1, 32'h00003344);
        check("lh_ld3", ld3, 32'h00003344);
        run_op(OP_LB, 32'h44, 32'h0, 1'b0, l1, l3, e1, e3, w1, w3);
        check("lb_ld1", ld1, 32'h00000044);
        check("lb_ld3", ld3, 32'h00000044);
        run_op(OP_LW, 32'h44, 32'h0, 1'b0, l1, l3, e1, e3, w1, w3);
        check("lw_lat1", 32'(l1), 32'd2);
        check("lw_lat3", 32'(l3), 32'd4);
        check("lw_ld1", ld1, 32'hAABB3344);
        check("lw_ld3", ld3, 32'hAABB3344);
        check("ld_nwr1", 32'(wr_cnt1 - wb1), 32'd0);
        check("ld_nwr3", 32'(wr_cnt3 - wb3), 32'd0);

        // SW: no read cycle
        run_op(OP_SW, 32'h80, 32'hDEADBEEF, 1'b0, l1, l3, e1, e3, w1, w3);
        check("sw_lat1", 32'(l1), 32'd2);
        check("sw_lat3", 32'(l3), 32'd2);
        check("sw_wcyc1", 32'(w1), 32'd1);
        check("sw_wcyc3", 32'(w3), 32'd1);
        check("sw_mem1", mem1[8'h80], 32'hDEADBEEF);
        check("sw_mem3", mem3[8'h80], 32'hDEADBEEF);
        check("sw_ld1", ld1, 32'hAABB3344);

        // Illegal op: immediate done with err, no access
        wb1 = wr_cnt1; wb3 = wr_cnt3;
        run_op(3'b111, 32'h40, 32'h55555555, 1'b0, l1, l3, e1, e3, w1, w3);
        check("ill_lat1", 32'(l1), 32'd1);
        check("ill_lat3", 32'(l3), 32'd1);
        check("ill_err1", 32'(e1), 32'd1);
        check("ill_err3", 32'(e3), 32'd1);
        check("ill_nwr1", 32'(wr_cnt1 - wb1), 32'd0);
        check("ill_nwr3", 32'(wr_cnt3 - wb3), 32'd0);
        check("ill_ld1", ld1, 32'hAABB3344);
        @(negedge clk);
        check("ill_err_clr1", 32'(err1), 32'd0);

        // Reset during RD of an SH
        repeat (2) @(negedge clk);
        wb1 = wr_cnt1; wb3 = wr_cnt3; db1 = dn_cnt1; db3 = dn_cnt3;
        @(negedge clk);
        start = 1'b1; op = OP_SH; addr = 32'h40; sdata = 32'h99999999;
        @(negedge clk);
        start = 1'b0;
        check("abort_inrd1", 32'(busy1), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy1", 32'(busy1), 32'd0);
        check("abort_busy3", 32'(busy3), 32'd0);
        check("abort_wr1", 32'(bus1.mem_wr), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_nwr1", 32'(wr_cnt1 - wb1), 32'd0);
        check("abort_nwr3", 32'(wr_cnt3 - wb3), 32'd0);
        check("abort_ndone1", 32'(dn_cnt1 - db1), 32'd0);
        check("abort_ndone3", 32'(dn_cnt3 - db3), 32'd0);
        check("abort_mem1", mem1[8'h40], 32'hAABBCC44);
        check("abort_mem3", mem3[8'h40], 32'hAABBCC44);
        run_op(OP_LW, 32'h40, 32'h0, 1'b0, l1, l3, e1, e3, w1, w3);
        check("post_lat1", 32'(l1), 32'd2);
        check("post_lat3", 32'(l3), 32'd4);
        check("post_ld1", ld1, 32'hAABBCC44);
        check("post_ld3", ld3, 32'hAABBCC44);

        // SW start pulsed while an LB is busy must be dropped
        repeat (2) @(negedge clk);
        wb1 = wr_cnt1; wb3 = wr_cnt3; db1 = dn_cnt1; db3 = dn_cnt3;
        run_op(OP_LB, 32'h44, 32'h0, 1'b1, l1, l3, e1, e3, w1, w3);
        repeat (6) @(negedge clk);
        check("drop_lat1", 32'(l1), 32'd2);
        check("drop_lat3", 32'(l3), 32'd4);
        check("drop_ndone1", 32'(dn_cnt1 - db1), 32'd1);
        check("drop_ndone3", 32'(dn_cnt3 - db3), 32'd1);
        check("drop_nwr1", 32'(wr_cnt1 - wb1), 32'd0);
        check("drop_nwr3", 32'(wr_cnt3 - wb3), 32'd0);
        check("drop_ld1", ld1, 32'h00000044);
        check("drop_mem1", mem1[8'h80], 32'hDEADBEEF);

        // Back-to-back: second start lands in the cycle after done
        run_op(OP_LW, 32'h40, 32'h0, 1'b0, l1, l3, e1, e3, w1, w3);
        run_op(OP_LH, 32'h44, 32'h0, 1'b0, l1, l3, e1, e3, w1, w3);
        check("b2b_lat1", 32'(l1), 32'd2);
        check("b2b_lat3", 32'(l3), 32'd4);
        check("b2b_ld1", ld1, 32'h00003344);
        check("b2b_ld3", ld3, 32'h00003344);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_subword_seq.md
Name: mem_subword_seq

Overview:
Multicycle sequencer between the datapath's memory-access control and the word-wide synchronous memory. It executes LW/LH/LB/SW/SH/SB as one handshake transaction. Sub-word stores run as read-modify-write: read the word, merge the low byte or half of B into it, write it back. Sub-word loads read the word and return the low byte or half, zero-extended. It replaces the loose MDR-plus-merge wiring with one block that has its own control.

Parameters:
MEM_LAT, 1, memory read latency in cycles (≥1); mem_rdata is valid at the end of the MEM_LAT-th cycle after the address is presented.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB; any other value is illegal
addr  input  32  word address, used unmodified
store_data  input  32  B register value
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse, coincident with done, for an illegal op
load_data  output  32  zero-extended load result; held until the next load completes
mem_addr  output  32  memory address
mem_wr  output  1  memory write enable
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: IDLE, RD (MEM_LAT cycles, wait counter), WR (1 cycle), DONE (1 cycle).
- Latching: in IDLE, start=1 latches op, addr and store_data. Inputs are ignored while busy, so start during busy is dropped.
- Transitions from IDLE on start:
  - LW/LH/LB/SH/SB → RD.
  - SW → WR.
  - Illegal op → DONE with err=1 and no memory access.
- RD: mem_addr = latched addr, mem_wr = 0. The counter runs 1..MEM_LAT. On the last RD cycle, mem_rdata is captured into the internal word register. Loads then go to DONE; SH/SB go to WR.
- WR: mem_wr = 1, mem_addr = latched addr, mem_wdata as follows:
  - SW: store_data.
  - SH: {word[31:16], store_data[15:0]}.
  - SB: {word[31:8], store_data[7:0]}.
- DONE: done = 1, then → IDLE. On a load, load_data updates at the RD→DONE edge:
  - LW: word.
  - LH: {16'b0, word[15:0]}.
  - LB: {24'b0, word[7:0]}.
- Latency in cycles after the start cycle until done is high:
  - Loads: MEM_LAT+1.
  - SH/SB: MEM_LAT+2.
  - SW: 2.
  - Illegal op: 1.
- Sub-word placement: the byte or half always occupies the low-order lane of the addressed word. addr[1:0] is not used for lane selection.
- Outputs outside RD/WR: mem_wr = 0, mem_wdata = 0, mem_addr = latched addr (0 after reset).
- Reset values: state IDLE, busy 0, done 0, err 0, load_data 0, mem_wr 0, mem_wdata 0, latched addr/op/data 0, counter 0.
- Reset mid-operation: the next edge forces IDLE. mem_wr is 0 from that edge on, no write is issued, done does not pulse, and load_data keeps its pre-op value.
- Back-to-back: a start in the cycle after DONE (now IDLE) is accepted. There is no start acceptance in the DONE cycle itself.
- mem_wr is decoded from registered state only, so it is glitch-free relative to clk.

Decomposition:
- Shared package mem_seq_pkg:
  - op encodings OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB.
  - state encoding S_IDLE, S_RD, S_WR, S_DONE.
- Sub-module mem_subword_merge (combinational): inputs op, word, store_data; outputs merged write word and zero-extended load word. The top level holds only the FSM, counter and registers.

Test Plan:
- Memory[0x40] = 0xAABBCCDD, MEM_LAT = 1, SB with store_data 0x11223344 → one read, then mem_wr = 1 with 0xAABBCC44 at 0x40. done is high 3 cycles after start; memory then reads 0xAABBCC44.
- Same initial word, SH with 0x11223344 → write 0xAABB3344. Then LH → load_data 0x00003344; LB → 0x00000044; LW → 0xAABB3344, with done 2 cycles after start.
- SW 0xDEADBEEF to 0x80 → no read cycle, mem_wr = 1 in cycle 1, done in cycle 2, memory holds 0xDEADBEEF. Repeat with MEM_LAT = 3: SB latency becomes 5, LW latency becomes 4.
- Illegal op 3'b111 → done = 1 and err = 1 in cycle 1, mem_wr never high, load_data unchanged.
- Start an SH and assert reset during RD → mem_wr stays 0, memory unchanged, busy = 0 after the reset edge, no done pulse. A fresh LW afterwards completes normally.
- Pulse start with op = SW during busy of an LB → ignored: exactly one done, no write. A start in the cycle after done is accepted.
